move_stream_reader: RTL and testbench
=====================================

MOVE_STREAM_READER -- requirements
Module: move_stream_reader

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1, one-cycle pulse that begins a drain pass.
REQ-004 SHALL have port col_done, input, 8, per-column generation-complete flags; bit c = column c.
REQ-005 SHALL have port col_empty, input, 8, per-column FIFO empty flags.
REQ-006 SHALL have port col_data, input, 1216, show-ahead FIFO heads; column c at [c*152 +: 152], valid whenever col_empty[c]=0.
REQ-007 SHALL have port col_rden, output, 8, one-hot pop strobe; one cycle pops one 152-bit word.
REQ-008 SHALL have port mv_valid, output, 1, move output valid.
REQ-009 SHALL have port mv_data, output, 19, move word {flag[6:0], from[5:0], to[5:0]}; flag = [invalid, promote, pawn move, pawn 2 sq, en passant, castle, capture].
REQ-010 SHALL have port mv_ready, input, 1, downstream accept.
REQ-011 SHALL have port mv_count, output, 8, moves emitted in current pass.
REQ-012 SHALL have port busy, output, 1, high in SCAN/EMIT.
REQ-013 SHALL have port done, output, 1, high in DONE.

Function
REQ-014 SHALL implement states IDLE, SCAN, EMIT, DONE, with 3-bit column pointer ptr, 3-bit slot index slot, and 152-bit word register wreg.
REQ-015 IDLE: when start=1, SHALL go to SCAN next cycle with ptr=0 and mv_count=0; start SHALL be ignored in SCAN/EMIT.
REQ-016 SCAN, col_empty[ptr]=0: SHALL assert col_rden[ptr] that cycle (combinational), load wreg from column ptr at that edge, set slot=0, and go to EMIT.
REQ-017 SCAN, all col_done=1 and all col_empty=1: SHALL go to DONE; this check SHALL take priority over pointer advance, and a non-empty ptr column SHALL take priority over it.
REQ-018 SCAN, otherwise: SHALL advance ptr by 1 modulo 8 (7 wraps to 0) and stay in SCAN.
REQ-019 EMIT: current slot s SHALL be wreg[s*19 +: 19]; slot 0 = bits [18:0], slot 7 = bits [151:133].
REQ-020 EMIT: a slot with bit 18 (invalid)=1 or value 19'd0 (padding) SHALL be skipped in one cycle with mv_valid=0.
REQ-021 EMIT, valid slot: SHALL hold mv_valid=1 and mv_data=slot value stable until mv_ready=1; the slot SHALL advance only on mv_valid & mv_ready.
REQ-022 EMIT: after slot 7 is accepted or skipped, SHALL return to SCAN with ptr=ptr+1 mod 8 (round-robin; no back-to-back pops of one column).
REQ-023 mv_data SHALL be 0 whenever mv_valid=0.
REQ-024 mv_count SHALL increment on each handshake and saturate at 255.
REQ-025 col_rden SHALL be zero outside SCAN and SHALL never have more than one bit set.
REQ-026 DONE: done SHALL stay 1 until reset; start in DONE SHALL begin a new pass exactly as from IDLE (REQ-015).
REQ-027 Latency: with column 0 non-empty and a valid slot 0, the first mv_valid SHALL rise 2 cycles after the start cycle.
REQ-028 mv_ready SHALL be ignored when mv_valid=0.

Reset
REQ-029 While reset=1, state SHALL go to IDLE; ptr, slot, wreg, mv_count SHALL be 0; mv_valid, mv_data, col_rden, busy, done SHALL be 0 on the following cycle.
REQ-030 Reset mid-EMIT SHALL discard wreg; the already-popped word is lost and SHALL NOT be re-emitted.
REQ-031 reset SHALL take priority over start in the same cycle.

Verification
REQ-032 Col 2 holds one word, slots {0x00A1C, invalid, 0x0...pad x6}, all col_done=1, mv_ready=1, start pulse -> col_rden=8'h04 exactly once, one move 0x00A1C emitted, mv_count=1, done=1.
REQ-033 Cols 0 and 5 each hold 2 full words of 8 valid moves -> pop order 0,5,0,5; 32 moves in slot order; mv_count=32; no cycle with two col_rden bits set.
REQ-034 mv_ready held 0 for 10 cycles mid-word -> mv_valid and mv_data stable for all 10 cycles; no slot lost or duplicated.
REQ-035 col_done=8'hFF, col_empty=8'hFF, start -> DONE 2 cycles after start, mv_count=0, no col_rden.
REQ-036 col_done=8'h7F with all FIFOs empty -> SCAN loops; ptr wraps 7->0; col_done[7] rises -> DONE within 8 cycles.
REQ-037 reset asserted during EMIT at slot 3 -> next cycle IDLE, all outputs 0; new start restarts at ptr=0, mv_count=0.

Source files
------------

// File: rtl/move_stream_reader.sv
// Move stream reader: drains eight per-column move FIFOs round-robin. It pops
// one 152-bit word (eight 19-bit move slots) at a time, skips invalid and
// padding slots, and hands valid moves downstream over a valid/ready handshake.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start
// SCAN  | looking at column ptr; pop it if non-empty, else advance ptr
// EMIT  | walking the slots of the popped word, one slot per step
// DONE  | all columns finished and drained; waits for reset or start
module move_stream_reader (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [7:0]    col_done,
    input  logic [7:0]    col_empty,
    input  logic [1215:0] col_data,
    output logic [7:0]    col_rden,
    output logic          mv_valid,
    output logic [18:0]   mv_data,
    input  logic          mv_ready,
    output logic [7:0]    mv_count,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_EMIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     ptr_q, ptr_d;
    logic [2:0]     slot_q, slot_d;
    logic [151:0]   wreg_q, wreg_d;
    logic [7:0]     mv_count_q, mv_count_d;

    logic [10:0]    col_base;
    logic [7:0]     slot_base;
    logic [18:0]    cur_slot;
    logic           slot_skip;
    logic           all_idle;

    assign col_base  = {8'd0, ptr_q} * 11'd152;
    assign slot_base = {5'd0, slot_q} * 8'd19;
    assign cur_slot  = wreg_q[slot_base +: 19];
    // Bit 18 marks an invalid slot; an all-zero slot is padding.
    assign slot_skip = cur_slot[18] | (cur_slot == 19'd0);
    assign all_idle  = (&col_done) & (&col_empty);

    // Next-state, pop strobe and move output decode.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        slot_d     = slot_q;
        wreg_d     = wreg_q;
        mv_count_d = mv_count_q;
        col_rden   = 8'd0;
        mv_valid   = 1'b0;
        mv_data    = 19'd0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_SCAN;
                    ptr_d      = 3'd0;
                    mv_count_d = 8'd0;
                end
            end
            S_SCAN: begin
                // A waiting word beats the termination check, which beats advancing.
                if (!col_empty[ptr_q]) begin
                    col_rden = 8'd1 << ptr_q;
                    wreg_d   = col_data[col_base +: 152];
                    slot_d   = 3'd0;
                    state_d  = S_EMIT;
                end else if (all_idle) begin
                    state_d = S_DONE;
                end else begin
                    ptr_d = ptr_q + 3'd1;
                end
            end
            S_EMIT: begin
                mv_valid = ~slot_skip;
                mv_data  = slot_skip ? 19'd0 : cur_slot;
                if (!slot_skip && mv_ready && (mv_count_q != 8'hFF))
                    mv_count_d = mv_count_q + 8'd1;
                if (slot_skip || mv_ready) begin
                    if (slot_q == 3'd7) begin
                        // Move on to the next column so one column cannot hog the reader.
                        state_d = S_SCAN;
                        ptr_d   = ptr_q + 3'd1;
                    end else begin
                        slot_d = slot_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= 3'd0;
            slot_q     <= 3'd0;
            wreg_q     <= 152'd0;
            mv_count_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            slot_q     <= slot_d;
            wreg_q     <= wreg_d;
            mv_count_q <= mv_count_d;
        end
    end

    assign mv_count = mv_count_q;
    assign busy     = (state_q == S_SCAN) || (state_q == S_EMIT);
    assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_move_stream_reader.sv
// Directed bench for move_stream_reader: behavioural show-ahead FIFOs per
// column, a handshake/pop monitor, and hand-computed expected move streams.
module tb_move_stream_reader;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    col_done;
    logic [7:0]    col_empty;
    logic [1215:0] col_data;
    logic [7:0]    col_rden;
    logic          mv_valid;
    logic [18:0]   mv_data;
    logic          mv_ready;
    logic [7:0]    mv_count;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    move_stream_reader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .col_done  (col_done),
        .col_empty (col_empty),
        .col_data  (col_data),
        .col_rden  (col_rden),
        .mv_valid  (mv_valid),
        .mv_data   (mv_data),
        .mv_ready  (mv_ready),
        .mv_count  (mv_count),
        .busy      (busy),
        .done      (done)
    );

    // Column FIFOs: written only by the stimulus, popped only on col_rden.
    logic [151:0] fifo_mem [8][8];
    int wr_cnt [8] = '{default: 0};
    int rd_idx [8] = '{default: 0};

    always_comb begin
        col_empty = 8'hFF;
        col_data  = '0;
        for (int c = 0; c < 8; c++) begin
            col_empty[c]           = (rd_idx[c] == wr_cnt[c]);
            col_data[c*152 +: 152] = fifo_mem[c][rd_idx[c] % 8];
        end
    end

    always @(posedge clk) begin
        for (int c = 0; c < 8; c++)
            if (col_rden[c]) rd_idx[c] <= rd_idx[c] + 1;
    end

    // Monitor: accepted moves, pop order and output invariants.
    logic [18:0] got [$];
    int pops [$];
    int multi_err = 0;
    int data_err  = 0;
    int rden_err  = 0;

    always @(negedge clk) begin
        if (mv_valid && mv_ready) got.push_back(mv_data);
        if ($countones(col_rden) > 1) multi_err++;
        if (!mv_valid && mv_data != 19'd0) data_err++;
        if (!busy && col_rden != 8'd0) rden_err++;
        for (int c = 0; c < 8; c++)
            if (col_rden[c]) pops.push_back(c);
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic load(input int c, input logic [151:0] w);
        fifo_mem[c][wr_cnt[c] % 8] = w;
        wr_cnt[c] = wr_cnt[c] + 1;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int n;
        n = 0;
        while (!done && n < max_cyc) begin
            tick();
            n++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    function automatic logic [18:0] mvb(input int c, input int w);
        return 19'(32'h1000 + c * 256 + w * 16);
    endfunction

    function automatic logic [151:0] mk_word(input logic [18:0] base);
        logic [151:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) w[i*19 +: 19] = base + 19'(i);
        return w;
    endfunction

    initial begin
        logic [151:0] w;
        logic [18:0]  held;
        int np, ng, bad, n, k;

        reset    = 1'b1;
        start    = 1'b0;
        col_done = 8'h00;
        mv_ready = 1'b0;
        do_reset();
        check("rst_valid", 32'(mv_valid), 32'd0);
        check("rst_data",  32'(mv_data),  32'd0);
        check("rst_rden",  32'(col_rden), 32'd0);
        check("rst_busy",  32'(busy),     32'd0);
        check("rst_done",  32'(done),     32'd0);
        check("rst_count", 32'(mv_count), 32'd0);

        // One word in column 2: one real move, one invalid, padding.
        col_done = 8'hFF;
        mv_ready = 1'b1;
        w = '0;
        w[18:0]  = 19'h00A1C;
        w[37:19] = 19'h40000;
        load(2, w);
        np = pops.size();
        ng = got.size();
        pulse_start();
        wait_done("t1_done", 50);
        check("t1_npops", 32'(pops.size() - np), 32'd1);
        check("t1_popcol", 32'(pops.size() > np ? pops[np] : 99), 32'd2);
        check("t1_nmoves", 32'(got.size() - ng), 32'd1);
        check("t1_move", 32'(got.size() > ng ? got[ng] : 19'd0), 32'h00A1C);
        check("t1_count", 32'(mv_count), 32'd1);

        // Columns 0 and 5, two full words each; restart directly from DONE.
        load(0, mk_word(mvb(0, 0)));
        load(0, mk_word(mvb(0, 1)));
        load(5, mk_word(mvb(5, 0)));
        load(5, mk_word(mvb(5, 1)));
        np = pops.size();
        ng = got.size();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("lat_scan_valid", 32'(mv_valid), 32'd0);
        check("lat_scan_rden",  32'(col_rden), 32'h01);
        tick();
        check("lat_emit_valid", 32'(mv_valid), 32'd1);
        check("lat_emit_data",  32'(mv_data),  32'(mvb(0, 0)));
        wait_done("t2_done", 300);
        check("t2_npops", 32'(pops.size() - np), 32'd4);
        bad = 0;
        for (int i = 0; i < 4; i++)
            if (pops.size() <= np + i || pops[np + i] != ((i % 2 == 0) ? 0 : 5)) bad++;
        check("t2_pop_order", 32'(bad), 32'd0);
        check("t2_nmoves", 32'(got.size() - ng), 32'd32);
        bad = 0;
        k = ng;
        for (int wi = 0; wi < 2; wi++)
            for (int ci = 0; ci < 2; ci++)
                for (int i = 0; i < 8; i++) begin
                    if (got.size() <= k || got[k] != mvb(ci * 5, wi) + 19'(i)) bad++;
                    k++;
                end
        check("t2_move_order", 32'(bad), 32'd0);
        check("t2_count", 32'(mv_count), 32'd32);

        // Downstream stall of ten cycles in the middle of a word.
        load(3, mk_word(mvb(3, 0)));
        ng = got.size();
        pulse_start();
        n = 0;
        while (got.size() < ng + 3 && n < 100) begin
            tick();
            n++;
        end
        mv_ready = 1'b0;
        held = mv_data;
        check("t3_held_slot", 32'(held), 32'(mvb(3, 0) + 19'd3));
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!mv_valid || mv_data != held) bad++;
        end
        check("t3_stable", 32'(bad), 32'd0);
        tick();
        mv_ready = 1'b1;
        wait_done("t3_done", 100);
        check("t3_nmoves", 32'(got.size() - ng), 32'd8);
        bad = 0;
        for (int i = 0; i < 8; i++)
            if (got.size() <= ng + i || got[ng + i] != mvb(3, 0) + 19'(i)) bad++;
        check("t3_order", 32'(bad), 32'd0);
        check("t3_count", 32'(mv_count), 32'd8);

        // Nothing to do at all: DONE two cycles after start.
        do_reset();
        np = pops.size();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_scan_busy", 32'(busy), 32'd1);
        check("t4_scan_done", 32'(done), 32'd0);
        tick();
        check("t4_done", 32'(done), 32'd1);
        check("t4_count", 32'(mv_count), 32'd0);
        check("t4_npops", 32'(pops.size() - np), 32'd0);

        // Column 7 unfinished: scanner loops and wraps until it completes.
        do_reset();
        col_done = 8'h7F;
        pulse_start();
        repeat (12) tick();
        check("t5_loop_busy", 32'(busy), 32'd1);
        check("t5_loop_done", 32'(done), 32'd0);
        w = '0;
        w[18:0] = 19'h00123;
        load(1, w);
        np = pops.size();
        ng = got.size();
        n = 0;
        while (pops.size() == np && n < 10) begin
            tick();
            n++;
        end
        check("t5_popcol", 32'(pops.size() > np ? pops[np] : 99), 32'd1);
        n = 0;
        while (got.size() == ng && n < 20) begin
            tick();
            n++;
        end
        check("t5_move", 32'(got.size() > ng ? got[ng] : 19'd0), 32'h00123);
        repeat (10) tick();
        check("t5_still_scan", 32'(done), 32'd0);
        col_done = 8'hFF;
        wait_done("t5_done", 8);
        check("t5_count", 32'(mv_count), 32'd1);

        // Reset in the middle of a word, with start in the same cycle.
        do_reset();
        load(6, mk_word(mvb(6, 0)));
        ng = got.size();
        pulse_start();
        n = 0;
        while (got.size() < ng + 3 && n < 60) begin
            tick();
            n++;
        end
        check("t6_slot3", 32'(mv_data), 32'(mvb(6, 0) + 19'd3));
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check("t6_rst_valid", 32'(mv_valid), 32'd0);
        check("t6_rst_data",  32'(mv_data),  32'd0);
        check("t6_rst_rden",  32'(col_rden), 32'd0);
        check("t6_rst_busy",  32'(busy),     32'd0);
        check("t6_rst_done",  32'(done),     32'd0);
        check("t6_rst_count", 32'(mv_count), 32'd0);
        tick();
        check("t6_start_ignored", 32'(busy), 32'd0);
        w = '0;
        w[18:0] = 19'h00321;
        load(0, w);
        w[18:0] = 19'h00777;
        load(7, w);
        np = pops.size();
        ng = got.size();
        pulse_start();
        wait_done("t6_done", 60);
        check("t6_npops", 32'(pops.size() - np), 32'd2);
        check("t6_first_pop", 32'(pops.size() > np ? pops[np] : 99), 32'd0);
        check("t6_nmoves", 32'(got.size() - ng), 32'd2);
        check("t6_move0", 32'(got.size() > ng ? got[ng] : 19'd0), 32'h00321);
        check("t6_move1", 32'(got.size() > ng + 1 ? got[ng + 1] : 19'd0), 32'h00777);
        check("t6_count", 32'(mv_count), 32'd2);

        check("onehot_rden", 32'(multi_err), 32'd0);
        check("data_zero_when_idle", 32'(data_err), 32'd0);
        check("rden_only_busy", 32'(rden_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
